// File: rtl/nor_burst_engine.sv
`default_nettype none
// nor_burst_engine: host byte-stream command engine sequencing timed NOR read/write/wait bursts.
// Rev 1.0
module nor_burst_engine #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 16,
   parameter int T_RD   = 4,
   parameter int T_WSU  = 2,
   parameter int T_WPW  = 4,
   parameter int T_WH   = 2,
   parameter int TMO_W  = 24
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ack,
   input  logic              out_space,
   output logic [7:0]        out_data,
   output logic              out_wr,
   output logic [ADDR_W-1:0] nor_a,
   output logic [DATA_W-1:0] nor_d_out,
   output logic              nor_d_oe,
   input  logic [DATA_W-1:0] nor_d_in,
   output logic              nor_ce_n,
   output logic              nor_oe_n,
   output logic              nor_we_n,
   output logic              nor_reset_n,
   output logic              nor_bus_oe,
   input  logic              nor_ready,
   output logic              busy
);
   localparam int A_BYTES = (ADDR_W + 7) / 8;
   localparam int D_BYTES = DATA_W / 8;
   localparam int TIM_W   = (TMO_W > 16) ? TMO_W : 16;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_CNT, S_RD, S_RDOUT, S_WDATA, S_WSU, S_WPW, S_WH, S_WAIT
   } state_t;

   state_t            r_state, w_state_nx;
   logic [ADDR_W-1:0] r_a, w_a_nx, w_a_inc;
   logic [DATA_W-1:0] r_data, w_data_nx;
   logic [DATA_W-1:0] r_dout, w_dout_nx;
   logic [15:0]       r_count, w_count_nx, r_words, w_words_nx;
   logic [TIM_W-1:0]  r_tim, w_tim_nx;
   logic [2:0]        r_idx, w_idx_nx;
   logic              r_inc, w_inc_nx, r_tmo, w_tmo_nx, r_doe, w_doe_nx;
   logic              r_ce_n, w_ce_n_nx, r_oe_n, w_oe_n_nx, r_we_n, w_we_n_nx;
   logic              r_rst_n, w_rst_n_nx, r_bus_oe, w_bus_oe_nx;
   logic [7:0]        w_status;

   assign w_a_inc  = r_a + ADDR_W'(1);
   assign w_status = {r_bus_oe, ~r_rst_n, nor_ready, r_tmo, 1'b0,
                      (DATA_W == 32), (DATA_W == 16), 1'b1};

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_data   <= '0;
         r_dout   <= '0;
         r_count  <= '0;
         r_words  <= '0;
         r_tim    <= '0;
         r_idx    <= '0;
         r_inc    <= 1'b0;
         r_tmo    <= 1'b0;
         r_doe    <= 1'b0;
         r_ce_n   <= 1'b1;
         r_oe_n   <= 1'b1;
         r_we_n   <= 1'b1;
         r_rst_n  <= 1'b0;
         r_bus_oe <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_a      <= w_a_nx;
         r_data   <= w_data_nx;
         r_dout   <= w_dout_nx;
         r_count  <= w_count_nx;
         r_words  <= w_words_nx;
         r_tim    <= w_tim_nx;
         r_idx    <= w_idx_nx;
         r_inc    <= w_inc_nx;
         r_tmo    <= w_tmo_nx;
         r_doe    <= w_doe_nx;
         r_ce_n   <= w_ce_n_nx;
         r_oe_n   <= w_oe_n_nx;
         r_we_n   <= w_we_n_nx;
         r_rst_n  <= w_rst_n_nx;
         r_bus_oe <= w_bus_oe_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_a_nx      = r_a;
      w_data_nx   = r_data;
      w_dout_nx   = r_dout;
      w_count_nx  = r_count;
      w_words_nx  = r_words;
      w_tim_nx    = r_tim;
      w_idx_nx    = r_idx;
      w_inc_nx    = r_inc;
      w_tmo_nx    = r_tmo;
      w_doe_nx    = r_doe;
      w_ce_n_nx   = r_ce_n;
      w_oe_n_nx   = r_oe_n;
      w_we_n_nx   = r_we_n;
      w_rst_n_nx  = r_rst_n;
      w_bus_oe_nx = r_bus_oe;
      in_ack      = 1'b0;
      out_wr      = 1'b0;
      out_data    = 8'h00;
      // With no downstream space the whole engine freezes, NOR strobes included.
      if (out_space) begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               in_ack   = 1'b1;
               w_inc_nx = in_data[0];
               w_idx_nx = '0;
               w_tim_nx = '0;
               case (in_data[7:4])
                  4'h0: case (in_data[3:0])
                     4'h1: begin out_wr = 1'b1; out_data = w_status; end
                     4'h2: w_bus_oe_nx = 1'b0;
                     4'h3: w_bus_oe_nx = 1'b1;
                     4'h4: w_rst_n_nx  = 1'b1;
                     4'h5: w_rst_n_nx  = 1'b0;
                     4'h6: w_state_nx  = S_ADDR;
                     4'h7: w_state_nx  = S_CNT;
                     default: ;
                  endcase
                  4'h1: begin
                     w_state_nx = S_RD;
                     w_words_nx = r_count;
                     w_ce_n_nx  = 1'b0;
                     w_oe_n_nx  = 1'b0;
                  end
                  4'h2: begin
                     w_state_nx = S_WDATA;
                     w_words_nx = r_count;
                  end
                  4'h3: begin
                     w_state_nx = S_WAIT;
                     w_tmo_nx   = 1'b0;
                  end
                  default: ;
               endcase
            end
            S_ADDR: if (in_valid) begin
               in_ack   = 1'b1;
               w_a_nx   = ADDR_W'({r_a, in_data});
               w_idx_nx = r_idx + 3'd1;
               if (r_idx == 3'(A_BYTES - 1)) w_state_nx = S_IDLE;
            end
            S_CNT: if (in_valid) begin
               in_ack     = 1'b1;
               w_count_nx = {r_count[7:0], in_data};
               w_idx_nx   = r_idx + 3'd1;
               if (r_idx == 3'd1) w_state_nx = S_IDLE;
            end
            S_RD: begin
               if (r_tim == TIM_W'(T_RD - 1)) begin
                  w_data_nx  = nor_d_in;
                  w_oe_n_nx  = 1'b1;
                  w_ce_n_nx  = 1'b1;
                  w_idx_nx   = '0;
                  w_state_nx = S_RDOUT;
               end else begin
                  w_tim_nx = r_tim + TIM_W'(1);
               end
            end
            S_RDOUT: begin
               out_wr    = 1'b1;
               out_data  = r_data[DATA_W-1 -: 8];
               w_data_nx = r_data << 8;
               w_idx_nx  = r_idx + 3'd1;
               if (r_idx == 3'(D_BYTES - 1)) begin
                  if (r_inc) w_a_nx = w_a_inc;
                  if (r_words == 16'd0) begin
                     w_state_nx = S_IDLE;
                  end else begin
                     w_words_nx = r_words - 16'd1;
                     w_tim_nx   = '0;
                     w_ce_n_nx  = 1'b0;
                     w_oe_n_nx  = 1'b0;
                     w_state_nx = S_RD;
                  end
               end
            end
            S_WDATA: if (in_valid) begin
               in_ack    = 1'b1;
               w_data_nx = DATA_W'({r_data, in_data});
               w_idx_nx  = r_idx + 3'd1;
               if (r_idx == 3'(D_BYTES - 1)) begin
                  w_dout_nx  = DATA_W'({r_data, in_data});
                  w_doe_nx   = 1'b1;
                  w_ce_n_nx  = 1'b0;
                  w_tim_nx   = '0;
                  w_state_nx = S_WSU;
               end
            end
            S_WSU: begin
               if (r_tim == TIM_W'(T_WSU - 1)) begin
                  w_we_n_nx  = 1'b0;
                  w_tim_nx   = '0;
                  w_state_nx = S_WPW;
               end else begin
                  w_tim_nx = r_tim + TIM_W'(1);
               end
            end
            S_WPW: begin
               if (r_tim == TIM_W'(T_WPW - 1)) begin
                  w_we_n_nx  = 1'b1;
                  w_tim_nx   = '0;
                  w_state_nx = S_WH;
               end else begin
                  w_tim_nx = r_tim + TIM_W'(1);
               end
            end
            S_WH: begin
               if (r_tim == TIM_W'(T_WH - 1)) begin
                  w_doe_nx  = 1'b0;
                  w_ce_n_nx = 1'b1;
                  if (r_inc) w_a_nx = w_a_inc;
                  if (r_words == 16'd0) begin
                     w_state_nx = S_IDLE;
                  end else begin
                     w_words_nx = r_words - 16'd1;
                     w_idx_nx   = '0;
                     w_state_nx = S_WDATA;
                  end
               end else begin
                  w_tim_nx = r_tim + TIM_W'(1);
               end
            end
            S_WAIT: begin
               if (nor_ready) begin
                  out_wr     = 1'b1;
                  out_data   = 8'h00;
                  if (r_inc) w_a_nx = w_a_inc;
                  w_state_nx = S_IDLE;
               end else if (&r_tim[TMO_W-1:0]) begin
                  out_wr     = 1'b1;
                  out_data   = 8'hFF;
                  w_tmo_nx   = 1'b1;
                  w_state_nx = S_IDLE;
               end else begin
                  w_tim_nx = r_tim + TIM_W'(1);
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   assign nor_a       = r_a;
   assign nor_d_out   = r_dout;
   assign nor_d_oe    = r_doe;
   assign nor_ce_n    = r_ce_n;
   assign nor_oe_n    = r_oe_n;
   assign nor_we_n    = r_we_n;
   assign nor_reset_n = r_rst_n;
   assign nor_bus_oe  = r_bus_oe;
   assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nor_burst_engine.sv
`default_nettype none
// tb_nor_burst_engine: directed command streams; expected bytes queued, checked by an output monitor.
// Rev 1.0
module tb_nor_burst_engine;
   localparam int ADDR_W = 23;
   localparam int DATA_W = 16;
   localparam int T_RD   = 4;
   localparam int T_WSU  = 2;
   localparam int T_WPW  = 4;
   localparam int T_WH   = 2;
   localparam int TMO_W  = 8;

   logic              mclk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ack;
   logic              out_space = 1'b1;
   logic [7:0]        out_data;
   logic              out_wr;
   logic [ADDR_W-1:0] nor_a;
   logic [DATA_W-1:0] nor_d_out;
   logic              nor_d_oe;
   logic [DATA_W-1:0] nor_d_in;
   logic              nor_ce_n, nor_oe_n, nor_we_n, nor_reset_n, nor_bus_oe;
   logic              nor_ready = 1'b1;
   logic              busy;

   always #5 mclk = ~mclk;
   assign nor_d_in = nor_a[15:0];

   nor_burst_engine #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_RD(T_RD), .T_WSU(T_WSU),
      .T_WPW(T_WPW), .T_WH(T_WH), .TMO_W(TMO_W)
   ) dut (
      .mclk(mclk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
      .out_space(out_space), .out_data(out_data), .out_wr(out_wr), .nor_a(nor_a),
      .nor_d_out(nor_d_out), .nor_d_oe(nor_d_oe), .nor_d_in(nor_d_in), .nor_ce_n(nor_ce_n),
      .nor_oe_n(nor_oe_n), .nor_we_n(nor_we_n), .nor_reset_n(nor_reset_n),
      .nor_bus_oe(nor_bus_oe), .nor_ready(nor_ready), .busy(busy)
   );

   int                errors = 0;
   int                checks = 0;
   logic [7:0]        exp_q[$];
   logic [7:0]        e;
   bit                sb_on = 1'b1;
   bit                toggle_en = 1'b0;
   int                stray_wr = 0;
   int                oe_runs[$], we_runs[$], doe_runs[$];
   int                oe_run = 0, we_run = 0, doe_run = 0;
   int                overlap_viol = 0, freeze_viol = 0;
   logic [ADDR_W-1:0] wr_a[$];
   logic [DATA_W-1:0] wr_d[$];
   logic              prev_space = 1'b1;
   logic [ADDR_W+3:0] prev_ctl = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output monitor and NOR bus observer, sampled on the falling edge.
   initial forever begin
      @(negedge mclk);
      if (out_wr) begin
         if (!sb_on) stray_wr++;
         else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %02h expected none", out_data);
         end else begin
            e = exp_q.pop_front();
            check("out_byte", {56'h0, out_data}, {56'h0, e});
         end
      end
      if ((nor_d_oe && !nor_oe_n) || (!nor_oe_n && !nor_we_n)) overlap_viol++;
      if (!nor_oe_n) oe_run++;
      else if (oe_run > 0) begin oe_runs.push_back(oe_run); oe_run = 0; end
      if (!nor_we_n) we_run++;
      else if (we_run > 0) begin
         we_runs.push_back(we_run);
         we_run = 0;
         wr_a.push_back(nor_a);
         wr_d.push_back(nor_d_out);
      end
      if (nor_d_oe) doe_run++;
      else if (doe_run > 0) begin doe_runs.push_back(doe_run); doe_run = 0; end
      if (!prev_space && ({nor_a, nor_ce_n, nor_oe_n, nor_we_n, nor_d_oe} !== prev_ctl))
         freeze_viol++;
      prev_ctl   = {nor_a, nor_ce_n, nor_oe_n, nor_we_n, nor_d_oe};
      prev_space = out_space;
   end

   initial forever begin
      @(posedge mclk);
      #1;
      out_space = toggle_en ? ~out_space : 1'b1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge mclk);
      while (!in_ack && n < 2000) begin @(negedge mclk); n++; end
      if (!in_ack) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %02h ack=%0b required 1", b, in_ack);
      end
      @(posedge mclk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic set_addr(input logic [23:0] a);
      send(8'h06); send(a[23:16]); send(a[15:8]); send(a[7:0]);
   endtask

   task automatic set_count(input logic [15:0] c);
      send(8'h07); send(c[15:8]); send(c[7:0]);
   endtask

   task automatic push2(input logic [15:0] w);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      @(negedge mclk);
      while ((busy || exp_q.size() != 0) && n < limit) begin @(negedge mclk); n++; end
      if (busy || exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy=%0b pending=%0d required idle and 0", name, busy, exp_q.size());
      end
      @(posedge mclk);
      #1;
   endtask

   task automatic check_reset_state(input string name);
      check(name, {out_wr, out_data, nor_a, nor_d_out, nor_d_oe, nor_ce_n, nor_oe_n,
                   nor_we_n, nor_reset_n, nor_bus_oe, busy},
            {1'b0, 8'h00, 23'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
   endtask

   initial begin
      repeat (3) @(posedge mclk);
      #1;
      check_reset_state("reset_values");
      reset = 1'b0;
      @(posedge mclk);
      #1;

      // Status bits after reset, bus on + reset asserted, then reset released.
      exp_q.push_back(8'h63); send(8'h01);
      send(8'h03); send(8'h05);
      exp_q.push_back(8'hE3); send(8'h01);
      send(8'h04);
      exp_q.push_back(8'hA3); send(8'h01);

      // Incrementing 3-word read.
      set_addr(24'h001234);
      set_count(16'd2);
      oe_runs.delete();
      push2(16'h1234); push2(16'h1235); push2(16'h1236);
      send(8'h11);
      wait_idle("read", 500);
      check("read_end_addr", nor_a, 23'h001237);
      check("read_oe_pulses", oe_runs.size(), 3);
      for (int i = 0; i < 3; i++) check("read_oe_width", oe_runs[i], T_RD);

      // Same kind of read with downstream space toggling.
      set_addr(24'h000100);
      set_count(16'd1);
      freeze_viol = 0;
      toggle_en = 1'b1;
      push2(16'h0100); push2(16'h0101);
      send(8'h11);
      wait_idle("stall_read", 1000);
      toggle_en = 1'b0;
      @(posedge mclk);
      #1;
      check("stall_end_addr", nor_a, 23'h000102);
      check("stall_frozen", freeze_viol, 0);

      // Two-word write wrapping the address, with an input gap mid-word.
      set_addr(24'h7FFFFF);
      set_count(16'd1);
      we_runs.delete(); doe_runs.delete(); wr_a.delete(); wr_d.delete();
      send(8'h21);
      send(8'hAA); send(8'h55); send(8'hBB);
      repeat (12) @(posedge mclk);
      #1;
      check("we_pulses_partial_word", we_runs.size(), 1);
      check("busy_waiting_data", busy, 1'b1);
      send(8'h66);
      wait_idle("write", 500);
      check("write_count", wr_a.size(), 2);
      check("write0_addr", wr_a[0], 23'h7FFFFF);
      check("write0_data", wr_d[0], 16'hAA55);
      check("write1_addr", wr_a[1], 23'h000000);
      check("write1_data", wr_d[1], 16'hBB66);
      for (int i = 0; i < 2; i++) begin
         check("we_width", we_runs[i], T_WPW);
         check("d_oe_width", doe_runs[i], T_WSU + T_WPW + T_WH);
      end
      check("write_end_addr", nor_a, 23'h000001);

      // Wait-for-ready: late ready, immediate ready, then timeout.
      nor_ready = 1'b0;
      exp_q.push_back(8'h00);
      send(8'h31);
      repeat (100) @(posedge mclk);
      #1;
      nor_ready = 1'b1;
      wait_idle("wait_ready", 100);
      check("wait_inc_addr", nor_a, 23'h000002);
      exp_q.push_back(8'h00);
      send(8'h30);
      wait_idle("wait_now", 50);
      check("wait_noinc_addr", nor_a, 23'h000002);
      nor_ready = 1'b0;
      exp_q.push_back(8'hFF);
      send(8'h31);
      wait_idle("wait_tmo", 1000);
      check("tmo_addr_held", nor_a, 23'h000002);
      exp_q.push_back(8'h93); send(8'h01);
      nor_ready = 1'b1;
      exp_q.push_back(8'h00); send(8'h31);
      wait_idle("wait_clear", 50);
      exp_q.push_back(8'hA3); send(8'h01);

      // Reset in the middle of a long read.
      set_addr(24'h000000);
      set_count(16'd5);
      sb_on = 1'b0;
      send(8'h10);
      repeat (10) @(posedge mclk);
      #1;
      reset = 1'b1;
      repeat (3) @(posedge mclk);
      #1;
      check_reset_state("midread_reset_values");
      stray_wr = 0;
      reset = 1'b0;
      repeat (30) @(posedge mclk);
      #1;
      check("no_out_wr_after_reset", stray_wr, 0);
      check("idle_after_reset", busy, 1'b0);
      sb_on = 1'b1;

      // Single-word read after reset, bus still off.
      set_addr(24'h00ABCD);
      push2(16'hABCD);
      send(8'h10);
      wait_idle("post_reset_read", 200);
      check("post_reset_addr", nor_a, 23'h00ABCD);

      check("strobe_overlap", overlap_viol, 0);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/nor_burst_engine.md
Name: nor_burst_engine

Overview:
- Parametrised successor to the PS3 NOR flasher command engine.
- Consumes a host byte stream carrying commands, address, count and write data, and runs timed NOR read/write/wait cycles.
- Generalised data/address width, programmable timing, hardware burst count (one command moves up to 65536 words), and wait-for-ready with timeout.
- Sits between the USB byte streamer (in/out byte handshakes) and top-level NOR pad tristate logic; exposes no inouts.

Parameters:
ADDR_W, 23, NOR address width (1..32); ADDR command carries ceil(ADDR_W/8) bytes, big-endian, excess MSBs ignored
DATA_W, 16, NOR data width; must be 8, 16 or 32; a word is DATA_W/8 bytes on the stream, MSB first
T_RD, 4, cycles oe asserted before nor_d_in is sampled (>=1)
T_WSU, 2, cycles data driven before we asserted (>=1)
T_WPW, 4, we_n low pulse width in cycles (>=1)
T_WH, 2, cycles data held after we deasserted (>=1)
TMO_W, 24, wait-timeout counter width; timeout = 2^TMO_W-1 cycles

Ports:
mclk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  host byte available
in_data  in  8  host byte
in_ack  out  1  consume in_data this cycle (combinational; only asserted when in_valid=1)
out_space  in  1  downstream can accept a byte
out_data  out  8  byte to host
out_wr  out  1  one-cycle strobe pushing out_data
nor_a  out  ADDR_W  address
nor_d_out  out  DATA_W  write data
nor_d_oe  out  1  drive nor_d_out onto pads
nor_d_in  in  DATA_W  pad read data (synchronised externally)
nor_ce_n, nor_oe_n, nor_we_n, nor_reset_n  out  1 each  NOR controls
nor_bus_oe  out  1  drive address/control pads at all
nor_ready  in  1  NOR RY/BY#
busy  out  1  state != S_IDLE

Behaviour:
- Reset: state S_IDLE; out_wr=0, out_data=0, nor_a=0, nor_d_out=0, nor_d_oe=0, nor_ce_n=1, nor_oe_n=1, nor_we_n=1, nor_reset_n=0 (asserted), nor_bus_oe=0, count=0, tmo_flag=0. Reset mid-burst aborts immediately; no further bytes emitted or consumed.
- Global stall: engine advances only when out_space=1; otherwise all state, counters and NOR outputs hold, in_ack=0, out_wr=0. in_ack only in byte-accepting states with in_valid=1.
- Commands (accepted in S_IDLE):
  0x00 NOP.
  0x01 STATUS: emit {nor_bus_oe, ~nor_reset_n, nor_ready, tmo_flag, busy_prev=0, DATA_W==32, DATA_W==16, 1'b1}.
  0x02/0x03 bus off/on (nor_bus_oe). 0x04/0x05 nor_reset_n deassert/assert.
  0x06 ADDR: -> S_ADDR, take ceil(ADDR_W/8) bytes shifting into nor_a.
  0x07 COUNT: -> S_CNT, take 2 bytes = words-1 (big-endian).
  0x1i READ, 0x2i WRITE, 0x3i WAIT; i[0]=1 post-increments nor_a per word. Other codes ignored as NOP.
- Address increment wraps 2^ADDR_W-1 -> 0. COUNT persists across bursts; not modified by bursts.
- READ: per word: ce_n=0, oe_n=0 for T_RD cycles; sample nor_d_in on last; oe_n=1, ce_n=1; emit DATA_W/8 bytes MSB first, one per unstalled cycle; increment if i[0]; repeat count+1 words, then S_IDLE.
- WRITE: per word: S_WDATA takes DATA_W/8 bytes (stall while in_valid=0, NOR idle); then nor_d_oe=1 + ce_n=0 for T_WSU, we_n=0 for T_WPW, we_n=1 for T_WH, then nor_d_oe=0, ce_n=1; increment; repeat.
- nor_d_oe never overlaps nor_oe_n=0; nor_oe_n and nor_we_n never both 0.
- WAIT: clears tmo_flag; counts until nor_ready=1 (emit 0x00, increment if i[0]) or counter reaches all-ones (emit 0xFF, set tmo_flag, no increment). nor_ready high on entry cycle completes immediately.
- nor_bus_oe=0 does not block sequencing; pads simply undriven.

Test Plan:
- Reset held 3 cycles mid-READ -> all outputs at reset values; no out_wr after release until new command.
- 0x06,0x00,0x12,0x34, 0x07,0x00,0x02, 0x11 with NOR model data=addr[15:0] -> bytes 12 34 12 35 12 36; nor_a=0x001237; oe low exactly T_RD cycles per word.
- ADDR 0x7FFFFF, COUNT 1, 0x21 with bytes AA 55 BB 66 -> writes 0xAA55 @0x7FFFFF, 0xBB66 @0x000000; we_n low T_WPW cycles; d_oe high T_WSU+T_WPW+T_WH.
- READ burst with out_space toggled every other cycle -> same byte sequence, no dupes/drops; NOR strobes frozen while stalled.
- 0x31 with nor_ready low 100 cycles -> single 0x00, nor_a+1; TMO_W=4 and ready stuck low -> 0xFF after 15 cycles, STATUS bit4=1.
- WRITE with in_valid gaps between data bytes -> no we_n pulse until full word received; STATUS after 0x03,0x05 -> bit7=1, bit6=1.
